// File: rtl/axi_id_pkg.sv
// Shared AXI ID helpers: default widths, the R-beat record and {seq, id} field split.
// Used by the read-ID restorer and its skid buffer.
package axi_id_pkg;

   localparam int ID_PAD_DEF     = 4;
   localparam int ID_WIDTH_DEF   = 2;
   localparam int DATA_WIDTH_DEF = 32;

   typedef struct packed {
      logic [ID_WIDTH_DEF-1:0]   id;
      logic [DATA_WIDTH_DEF-1:0] data;
      logic [1:0]                resp;
      logic                      last;
   } r_beat_t;

   localparam int R_BEAT_W = $bits(r_beat_t);

   function automatic logic [ID_WIDTH_DEF-1:0] rid_id(input logic [ID_WIDTH_DEF+ID_PAD_DEF-1:0] rid);
      return rid[ID_WIDTH_DEF-1:0];
   endfunction

   function automatic logic [ID_PAD_DEF-1:0] rid_seq(input logic [ID_WIDTH_DEF+ID_PAD_DEF-1:0] rid);
      return rid[ID_WIDTH_DEF+ID_PAD_DEF-1:ID_WIDTH_DEF];
   endfunction

endpackage

// File: rtl/r_skid_buffer.sv
// 2-entry valid/ready FIFO, order preserving; 1-cycle latency when empty.
// Backpressure: in_rdy_o drops as soon as both entries are occupied.
module r_skid_buffer
   import axi_id_pkg::*;
#(
   parameter int W = R_BEAT_W
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         in_vld_i,
   input  logic [W-1:0] in_dat_i,
   output logic         in_rdy_o,
   output logic         out_vld_o,
   output logic [W-1:0] out_dat_o,
   input  logic         out_rdy_i
);

   logic [W-1:0] mem_q [2];
   logic         wr_ptr_q, rd_ptr_q;
   logic [1:0]   cnt_q, cnt_d;
   logic         push, pop;

   assign in_rdy_o  = (cnt_q != 2'd2);
   assign out_vld_o = (cnt_q != 2'd0);
   assign out_dat_o = mem_q[rd_ptr_q];
   assign push      = in_vld_i && in_rdy_o;
   assign pop       = out_vld_o && out_rdy_i;

   always_comb begin
      cnt_d = cnt_q;
      if (push && !pop) begin
         cnt_d = cnt_q + 2'd1;
      end else if (pop && !push) begin
         cnt_d = cnt_q - 2'd1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         cnt_q    <= 2'd0;
      end else begin
         if (push) begin
            mem_q[wr_ptr_q] <= in_dat_i;
            wr_ptr_q        <= ~wr_ptr_q;
         end
         if (pop) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/read_id_restorer.sv
// Strips the sequence field from RID, forwards beats via a 2-entry skid buffer (1-cycle latency),
// tracks per-ID outstanding reads and expected sequence; S_RREADY low only when the buffer is full.
module read_id_restorer
   import axi_id_pkg::*;
#(
   parameter int ID_PAD     = ID_PAD_DEF,
   parameter int ID_WIDTH   = ID_WIDTH_DEF,
   parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
   input  logic                         Aclk,
   input  logic                         ARESETnRst,
   input  logic [ID_WIDTH-1:0]          AR_ID,
   input  logic                         AR_valid,
   input  logic                         AR_Ready,
   output logic                         AR_hold,
   input  logic [ID_WIDTH+ID_PAD-1:0]   S_RID,
   input  logic [DATA_WIDTH-1:0]        S_RDATA,
   input  logic [1:0]                   S_RRESP,
   input  logic                         S_RLAST,
   input  logic                         S_RVALID,
   output logic                         S_RREADY,
   output logic [ID_WIDTH-1:0]          M_RID,
   output logic [DATA_WIDTH-1:0]        M_RDATA,
   output logic [1:0]                   M_RRESP,
   output logic                         M_RLAST,
   output logic                         M_RVALID,
   input  logic                         M_RREADY,
   output logic                         seq_err,
   output logic                         orphan_err,
   output logic [ID_WIDTH-1:0]          err_id
);

   localparam int              NUM_ID  = 1 << ID_WIDTH;
   localparam int              BEAT_W  = ID_WIDTH + DATA_WIDTH + 3;
   localparam logic [ID_PAD:0] OUT_MAX = {1'b1, {ID_PAD{1'b0}}};

   logic [ID_WIDTH-1:0] s_id;
   logic [ID_PAD-1:0]   s_seq;
   logic                s_acc, ar_fire, seq_bad, orph;
   logic [NUM_ID-1:0]   ar_hit, r_done;
   logic [BEAT_W-1:0]   in_beat, out_beat;

   logic [ID_PAD-1:0]   exp_seq_q     [NUM_ID];
   logic [ID_PAD-1:0]   exp_seq_d     [NUM_ID];
   logic [ID_PAD:0]     outstanding_q [NUM_ID];
   logic [ID_PAD:0]     outstanding_d [NUM_ID];
   logic                seq_err_q, orphan_err_q;
   logic [ID_WIDTH-1:0] err_id_q;

   assign s_id    = S_RID[ID_WIDTH-1:0];
   assign s_seq   = S_RID[ID_WIDTH+ID_PAD-1:ID_WIDTH];
   assign s_acc   = S_RVALID && S_RREADY;
   assign ar_fire = AR_valid && AR_Ready;
   assign AR_hold = (outstanding_q[AR_ID] == OUT_MAX);

   assign seq_bad = s_acc && (s_seq != exp_seq_q[s_id]);
   assign orph    = s_acc && (outstanding_q[s_id] == '0);

   assign in_beat = {s_id, S_RDATA, S_RRESP, S_RLAST};
   assign {M_RID, M_RDATA, M_RRESP, M_RLAST} = out_beat;

   r_skid_buffer #(.W(BEAT_W)) u_skid (
      .clk_i     (Aclk),
      .rst_ni    (ARESETnRst),
      .in_vld_i  (S_RVALID),
      .in_dat_i  (in_beat),
      .in_rdy_o  (S_RREADY),
      .out_vld_o (M_RVALID),
      .out_dat_o (out_beat),
      .out_rdy_i (M_RREADY)
   );

   always_comb begin
      ar_hit = '0;
      r_done = '0;
      if (ar_fire) ar_hit[AR_ID] = 1'b1;
      if (s_acc && S_RLAST) r_done[s_id] = 1'b1;
   end

   // An orphan last-beat does not decrement, so a same-cycle AR on that ID still counts.
   always_comb begin
      for (int i = 0; i < NUM_ID; i++) begin
         exp_seq_d[i]     = exp_seq_q[i];
         outstanding_d[i] = outstanding_q[i];
         if (r_done[i]) begin
            exp_seq_d[i] = exp_seq_q[i] + ID_PAD'(1);
         end
         if (ar_hit[i] && !(r_done[i] && outstanding_q[i] != '0)) begin
            if (outstanding_q[i] != OUT_MAX) begin
               outstanding_d[i] = outstanding_q[i] + (ID_PAD+1)'(1);
            end
         end else if (r_done[i] && !ar_hit[i] && outstanding_q[i] != '0) begin
            outstanding_d[i] = outstanding_q[i] - (ID_PAD+1)'(1);
         end
      end
   end

   always_ff @(posedge Aclk or negedge ARESETnRst) begin
      if (!ARESETnRst) begin
         for (int i = 0; i < NUM_ID; i++) begin
            exp_seq_q[i]     <= '0;
            outstanding_q[i] <= '0;
         end
         seq_err_q    <= 1'b0;
         orphan_err_q <= 1'b0;
         err_id_q     <= '0;
      end else begin
         for (int i = 0; i < NUM_ID; i++) begin
            exp_seq_q[i]     <= exp_seq_d[i];
            outstanding_q[i] <= outstanding_d[i];
         end
         seq_err_q    <= seq_bad;
         orphan_err_q <= orph;
         if (seq_bad || orph) begin
            err_id_q <= s_id;
         end
      end
   end

   assign seq_err    = seq_err_q;
   assign orphan_err = orphan_err_q;
   assign err_id     = err_id_q;

endmodule

// File: tb/tb_read_id_restorer.sv
// Directed bench for read_id_restorer: vector table for the streaming path plus
// hand-written sequences for backpressure, reset and sequence wrap.
module tb_read_id_restorer;

   logic        Aclk = 1'b0;
   logic        ARESETnRst;
   logic [1:0]  AR_ID;
   logic        AR_valid, AR_Ready, AR_hold;
   logic [5:0]  S_RID;
   logic [31:0] S_RDATA;
   logic [1:0]  S_RRESP;
   logic        S_RLAST, S_RVALID, S_RREADY;
   logic [1:0]  M_RID;
   logic [31:0] M_RDATA;
   logic [1:0]  M_RRESP;
   logic        M_RLAST, M_RVALID, M_RREADY;
   logic        seq_err, orphan_err;
   logic [1:0]  err_id;

   int checks   = 0;
   int failures = 0;

   always #5 Aclk = ~Aclk;

   read_id_restorer dut (
      .Aclk(Aclk), .ARESETnRst(ARESETnRst),
      .AR_ID(AR_ID), .AR_valid(AR_valid), .AR_Ready(AR_Ready), .AR_hold(AR_hold),
      .S_RID(S_RID), .S_RDATA(S_RDATA), .S_RRESP(S_RRESP), .S_RLAST(S_RLAST),
      .S_RVALID(S_RVALID), .S_RREADY(S_RREADY),
      .M_RID(M_RID), .M_RDATA(M_RDATA), .M_RRESP(M_RRESP), .M_RLAST(M_RLAST),
      .M_RVALID(M_RVALID), .M_RREADY(M_RREADY),
      .seq_err(seq_err), .orphan_err(orphan_err), .err_id(err_id)
   );

   typedef struct {
      logic        ar;
      logic [1:0]  ar_id;
      logic        rv;
      logic [3:0]  seq;
      logic [1:0]  id;
      logic [31:0] dat;
      logic        last;
      logic        e_seq;
      logic        e_orph;
      logic [1:0]  e_eid;
   } vec_t;

   vec_t tbl [17];

   function automatic vec_t mk(input logic ar, input logic [1:0] ar_id, input logic rv,
                               input logic [3:0] seq, input logic [1:0] id, input logic [31:0] dat,
                               input logic last, input logic e_seq, input logic e_orph,
                               input logic [1:0] e_eid);
      vec_t v;
      v.ar = ar; v.ar_id = ar_id; v.rv = rv; v.seq = seq; v.id = id; v.dat = dat;
      v.last = last; v.e_seq = e_seq; v.e_orph = e_orph; v.e_eid = e_eid;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   // One clock: drive AR and/or an R beat, clock it, then idle the request lines.
   task automatic cyc(input logic ar, input logic [1:0] ar_id, input logic rv,
                      input logic [3:0] seq, input logic [1:0] id, input logic [31:0] dat,
                      input logic last);
      AR_valid = ar;
      AR_Ready = ar;
      AR_ID    = ar_id;
      S_RVALID = rv;
      S_RID    = {seq, id};
      S_RDATA  = dat;
      S_RRESP  = dat[1:0];
      S_RLAST  = last;
      @(posedge Aclk);
      #1;
      AR_valid = 1'b0;
      AR_Ready = 1'b0;
      S_RVALID = 1'b0;
   endtask

   initial begin
      int          n_acc;
      logic        acc;
      logic [31:0] base;

      ARESETnRst = 1'b0;
      AR_ID = '0; AR_valid = 1'b0; AR_Ready = 1'b0;
      S_RID = '0; S_RDATA = '0; S_RRESP = '0; S_RLAST = 1'b0; S_RVALID = 1'b0;
      M_RREADY = 1'b1;

      //            ar  arid rv seq id  data           last eseq eorph eid
      tbl[0]  = mk(1, 1, 0, 0, 0, 32'h0,          0, 0, 0, 0);
      tbl[1]  = mk(1, 1, 0, 0, 0, 32'h0,          0, 0, 0, 0);
      tbl[2]  = mk(1, 1, 0, 0, 0, 32'h0,          0, 0, 0, 0);
      tbl[3]  = mk(0, 0, 1, 0, 1, 32'hA000_0000,  0, 0, 0, 0);
      tbl[4]  = mk(0, 0, 1, 0, 1, 32'hA000_0001,  1, 0, 0, 0);
      tbl[5]  = mk(0, 0, 1, 1, 1, 32'hB000_0002,  0, 0, 0, 0);
      tbl[6]  = mk(0, 0, 1, 1, 1, 32'hB000_0003,  1, 0, 0, 0);
      tbl[7]  = mk(0, 0, 1, 2, 1, 32'hC000_0000,  0, 0, 0, 0);
      tbl[8]  = mk(0, 0, 1, 2, 1, 32'hC000_0001,  1, 0, 0, 0);
      tbl[9]  = mk(1, 3, 0, 0, 0, 32'h0,          0, 0, 0, 0);
      tbl[10] = mk(0, 0, 1, 2, 3, 32'hD000_0002,  1, 1, 0, 3);
      tbl[11] = mk(0, 0, 0, 0, 0, 32'h0,          0, 0, 0, 3);
      tbl[12] = mk(0, 0, 1, 0, 2, 32'hE000_0003,  1, 0, 1, 2);
      tbl[13] = mk(0, 0, 0, 0, 0, 32'h0,          0, 0, 0, 2);
      tbl[14] = mk(0, 0, 1, 3, 1, 32'hF000_0001,  1, 0, 1, 1);
      tbl[15] = mk(0, 0, 1, 5, 3, 32'h1234_5672,  0, 1, 1, 3);
      tbl[16] = mk(0, 0, 0, 0, 0, 32'h0,          0, 0, 0, 3);

      #12;
      chk("rst M_RVALID", M_RVALID, 0);
      chk("rst M_RID", M_RID, 0);
      chk("rst M_RDATA", M_RDATA, 0);
      chk("rst M_RRESP", M_RRESP, 0);
      chk("rst M_RLAST", M_RLAST, 0);
      chk("rst S_RREADY", S_RREADY, 1);
      chk("rst seq_err", seq_err, 0);
      chk("rst orphan_err", orphan_err, 0);
      chk("rst err_id", err_id, 0);
      @(posedge Aclk);
      #1 ARESETnRst = 1'b1;

      for (int r = 0; r < 17; r++) begin
         cyc(tbl[r].ar, tbl[r].ar_id, tbl[r].rv, tbl[r].seq, tbl[r].id, tbl[r].dat, tbl[r].last);
         chk($sformatf("row%0d M_RVALID", r), M_RVALID, tbl[r].rv);
         if (tbl[r].rv) begin
            chk($sformatf("row%0d M_RID", r), M_RID, tbl[r].id);
            chk($sformatf("row%0d M_RDATA", r), M_RDATA, tbl[r].dat);
            chk($sformatf("row%0d M_RRESP", r), M_RRESP, tbl[r].dat[1:0]);
            chk($sformatf("row%0d M_RLAST", r), M_RLAST, tbl[r].last);
         end
         chk($sformatf("row%0d seq_err", r), seq_err, tbl[r].e_seq);
         chk($sformatf("row%0d orphan_err", r), orphan_err, tbl[r].e_orph);
         chk($sformatf("row%0d err_id", r), err_id, tbl[r].e_eid);
      end

      // Backpressure: continuous stream into a stalled master.
      base     = 32'h5EED_0000;
      n_acc    = 0;
      M_RREADY = 1'b0;
      for (int k = 0; k < 5; k++) begin
         S_RVALID = 1'b1;
         S_RID    = {4'd0, 2'd2};
         S_RDATA  = base + 32'(n_acc);
         S_RRESP  = 2'd0;
         S_RLAST  = 1'b0;
         acc      = S_RREADY;
         @(posedge Aclk);
         #1;
         if (acc) n_acc++;
         if (k >= 2) chk($sformatf("bp stall data k%0d", k), M_RDATA, base);
      end
      S_RVALID = 1'b0;
      chk("bp accepted", 32'(n_acc), 2);
      chk("bp S_RREADY full", S_RREADY, 0);
      chk("bp M_RVALID", M_RVALID, 1);
      M_RREADY = 1'b1;
      chk("drain head0", M_RDATA, base);
      @(posedge Aclk); #1;
      chk("drain vld1", M_RVALID, 1);
      chk("drain head1", M_RDATA, base + 32'd1);
      @(posedge Aclk); #1;
      chk("drain empty", M_RVALID, 0);

      // Refill to two entries, then reset asynchronously mid-cycle.
      M_RREADY = 1'b0;
      cyc(0, 0, 1, 0, 2, 32'h7700_0001, 0);
      cyc(0, 0, 1, 0, 2, 32'h7700_0002, 1);
      chk("refill S_RREADY", S_RREADY, 0);
      #2 ARESETnRst = 1'b0;
      #1;
      chk("arst M_RVALID", M_RVALID, 0);
      chk("arst S_RREADY", S_RREADY, 1);
      chk("arst M_RDATA", M_RDATA, 0);
      chk("arst seq_err", seq_err, 0);
      @(posedge Aclk);
      #1 ARESETnRst = 1'b1;
      M_RREADY = 1'b1;

      // exp_seq[1] and outstanding[1] must both be back at zero.
      cyc(0, 0, 1, 0, 1, 32'h0BAD_0001, 1);
      chk("post-rst seq_err", seq_err, 0);
      chk("post-rst orphan_err", orphan_err, 1);
      chk("post-rst err_id", err_id, 1);

      // Saturate ID 0, then wrap its sequence.
      for (int k = 0; k < 16; k++) cyc(1, 0, 0, 0, 0, 32'h0, 0);
      AR_ID = 2'd0; #1;
      chk("hold id0 full", AR_hold, 1);
      AR_ID = 2'd1; #1;
      chk("hold id1 free", AR_hold, 0);
      for (int k = 0; k < 16; k++) begin
         // Beat 1 carries a same-cycle AR on ID 0, which must leave the count unchanged.
         cyc(k == 1, 0, 1, 4'(k), 0, 32'h9000_0000 + 32'(k), 1);
         chk($sformatf("wrap beat%0d errs", k), {30'd0, seq_err, orphan_err}, 0);
         if (k == 0) begin
            AR_ID = 2'd0; #1;
            chk("hold id0 released", AR_hold, 0);
         end
      end
      cyc(0, 0, 1, 0, 0, 32'h9100_0000, 1);
      chk("wrap seq0 seq_err", seq_err, 0);
      chk("wrap extra orphan_err", orphan_err, 0);
      cyc(0, 0, 1, 1, 0, 32'h9100_0001, 1);
      chk("wrap drained orphan_err", orphan_err, 1);
      chk("wrap drained seq_err", seq_err, 0);
      chk("wrap drained err_id", err_id, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/read_id_restorer.md
# read_id_restorer

Return-path companion to the read-ID generator on the AXI read path of the node. It accepts R beats whose RID is {sequence, original ID}, strips the sequence field, and forwards beats to the master with the original ID through a 2-entry skid buffer. It tracks per-ID outstanding reads from the AR handshake and per-ID expected sequence numbers, and flags out-of-order or orphan responses.

## Interface
- ID_PAD, 4: sequence field width; per-ID counters wrap modulo 2^ID_PAD.
- ID_WIDTH, 2: original ID width; 2^ID_WIDTH independent trackers.
- DATA_WIDTH, 32: RDATA width.

Ports:
- Aclk  in  1  clock; single clock domain, all logic on rising edge.
- ARESETnRst  in  1  asynchronous, active-low reset.
- AR_ID  in  ID_WIDTH  AR-channel original ID, observed only.
- AR_valid  in  1  AR valid, observed only.
- AR_Ready  in  1  AR ready, observed only.
- AR_hold  out  1  combinational; 1 when outstanding[AR_ID] == 2^ID_PAD. Upstream must not complete an AR handshake while it is high.
- S_RID  in  ID_WIDTH+ID_PAD  slave RID: {seq, id}, with id in the low bits.
- S_RDATA  in  DATA_WIDTH  read data.
- S_RRESP  in  2  read response.
- S_RLAST  in  1  last beat of the burst.
- S_RVALID  in  1  slave beat valid.
- S_RREADY  out  1  buffer not full.
- M_RID  out  ID_WIDTH  restored ID.
- M_RDATA  out  DATA_WIDTH  data.
- M_RRESP  out  2  response.
- M_RLAST  out  1  last.
- M_RVALID  out  1  master beat valid.
- M_RREADY  in  1  master ready.
- seq_err  out  1  one-cycle pulse: beat sequence field != expected.
- orphan_err  out  1  one-cycle pulse: beat arrived for an ID with zero outstanding.
- err_id  out  ID_WIDTH  ID of the most recent error, held until the next error.

## Operation
- Slave accept: S_RVALID && S_RREADY. Master accept: M_RVALID && M_RREADY.
- Field split: id = S_RID[ID_WIDTH-1:0]; seq = S_RID[ID_WIDTH+ID_PAD-1:ID_WIDTH].
- Skid buffer: 2-entry FIFO of {id, data, resp, last}. S_RREADY = (occupancy < 2). M_* outputs come from the head entry. Order is preserved.
- exp_seq[i] (ID_PAD bits): increments modulo 2^ID_PAD on a slave accept with S_RLAST for id i.
- outstanding[i] (ID_PAD+1 bits):
  - +1 on AR_valid && AR_Ready with AR_ID == i.
  - −1 on a slave accept with S_RLAST for id i.
  - Both in the same cycle for the same i: unchanged.
  - Never decremented below 0.
- Checks, on every slave accept:
  - seq != exp_seq[id] → seq_err pulses.
  - outstanding[id] == 0 (registered value) → orphan_err pulses. The beat is still forwarded and counters do not decrement.
  - Both errors may pulse together. err_id is updated with id.
- The beat is forwarded regardless of errors. Error handling is the system's responsibility.
- AR-side overflow while AR_hold is high is a protocol violation. The count saturates at 2^ID_PAD.

## Timing
- Reset values: M_RVALID=0, M_RID/M_RDATA/M_RRESP/M_RLAST=0, S_RREADY=1, seq_err=0, orphan_err=0, err_id=0. All exp_seq and outstanding counters and the buffer occupancy are 0.
- Latency: a beat accepted in cycle N appears on M_* with M_RVALID=1 in cycle N+1 if the buffer was empty.
- Throughput: 1 beat/cycle while M_RREADY=1.
- M_* payload is stable while M_RVALID && !M_RREADY.
- Occupancy 2 → S_RREADY=0 in the same cycle.
- Simultaneous slave and master accept at occupancy 2 is impossible because S_RREADY=0. At occupancy 1, both accepts leave occupancy at 1.
- seq_err, orphan_err and err_id are registered: they are valid the cycle after the offending accept.
- exp_seq wrap: 2^ID_PAD−1 → 0. The next expected sequence is 0 with no error.
- Reset mid-burst: all state clears immediately and asynchronously. Buffered beats are dropped.

## Structure
- Shared package axi_id_pkg:
  - default ID_PAD and ID_WIDTH constants;
  - r_beat_t typedef {id, data, resp, last};
  - helper functions splitting {seq, id}.
- Sub-module r_skid_buffer: a 2-entry valid/ready FIFO of r_beat_t, parameterised on payload width. It is reusable for the B channel.
- The top level holds the counter arrays, the checks and the error registers.

## Test plan
- AR ID 1 three times, then R bursts with RID {0,1}, {1,1}, {2,1}, each 2 beats with RLAST on the 2nd → M_RID=1 on all 6 beats. No errors. outstanding[1] returns to 0. exp_seq[1]=3.
- Single-beat R with RID {2,3} while exp_seq[3]=0 and outstanding[3]=1 → seq_err=1 for one cycle, err_id=3. The beat is forwarded with M_RID=3.
- R beat for ID 2 with no prior AR → orphan_err=1, err_id=2. outstanding[2] stays 0.
- M_RREADY=0 with a continuous S_RVALID stream → exactly 2 beats are accepted, then S_RREADY=0. Releasing M_RREADY drains the beats in order, one per cycle.
- 16 ARs on ID 0 with ID_PAD=4 → AR_hold=1. Sixteen single-beat R with seq 0..15 → no errors, exp_seq[0] wraps to 0, AR_hold=0. The same-cycle AR and R-last on ID 0 leaves the count unchanged.
- Assert reset while the buffer holds 2 beats → M_RVALID=0 and S_RREADY=1 immediately. All counters are 0 after release.
